prio_arb_enc: RTL and testbench
===============================

Name: prio_arb_enc

Overview:
- Parametrised, registered successor to the team's 4-input priority encoder.
- Accumulates N request lines into a sticky pending set and selects one index per grant. Selection is either fixed priority (highest index wins) or round-robin.
- Presents the selected index on a valid/ready handshake to a downstream consumer.
- Sits between interrupt/event sources and a single-issue service engine.

Parameters:
- N, 8, number of request lines; legal range 2..64.
- CW, $clog2(N), width of the code output; derived, do not override.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request pulses or levels; each asserted bit sets its pending bit.
- mode  in  1  0 = FIXED (highest index first), 1 = RR (round-robin); sampled only when a new grant is loaded.
- code  out  CW  granted index; stable while valid=1 and ready=0.
- valid  out  1  code holds an unaccepted grant.
- ready  in  1  consumer accepts code when valid&&ready at a rising edge.
- pending  out  N  current pending set (registered), for debug/status.

Behaviour:
- Reset (rst=1 at edge): pending=0, code=0, valid=0, rr_ptr=0, state=IDLE. Reset overrides any handshake in the same cycle.
- Pending update, every edge: pending <= (pending & ~clr) | req. clr is one-hot of code when valid&&ready, else 0. A req on the bit being cleared re-arms it, so the new request wins.
- Selection source: cand = pending & ~clr, plus req. The same-cycle req is visible, giving latency 1 cycle from req edge to valid.
- FIXED selection: highest set index of cand.
- RR selection: search order is rr_ptr-1, rr_ptr-2, ..., 0, N-1, ..., rr_ptr (descending, wrapping). After reset rr_ptr=0, so the first RR grant equals the FIXED result.
- rr_ptr <= code on every accepted grant, in both modes. This keeps mode switches deterministic.
- FSM states:
  - IDLE: valid=0. If cand!=0: load code=select(cand), valid<=1, go GRANT. Otherwise stay.
  - GRANT: valid=1, code held.
    - If ready=0: stay and hold code, even if higher-priority requests arrive (no preemption).
    - If ready=1 and cand!=0 after clearing: load next code, valid stays 1, stay in GRANT (back-to-back, 1 grant/cycle).
    - If ready=1 and cand==0: valid<=0, go IDLE.
- Widths: code is zero-extended index, CW bits. With N not a power of two, codes >= N never occur.
- Boundaries:
  - All N bits pending in RR: each index is granted exactly once in N consecutive accepts, in descending wrapped order.
  - ready asserted while valid=0 is ignored.
  - Reset mid-GRANT drops the grant and all pending bits; the consumer must not count an accept in that cycle.
  - mode toggling while in GRANT does not change the held code.

Decomposition:
- Package prio_arb_pkg:
  - typedef enum logic {FIXED=1'b0, RR=1'b1} arb_mode_t.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
- Sub-module prio_enc_n (combinational): N-bit input, outputs CW-bit index of the highest set bit plus a found flag. Instantiate once on the rotated candidate vector for RR and once on the raw vector for FIXED; top level un-rotates the RR result modulo N.

Test Plan (N=8):
1. FIXED, req=8'b0100_1010 one cycle, ready=1 → codes 6,3,1 on three consecutive cycles with valid=1; valid=0 on the 4th; pending=0.
2. FIXED backpressure: req=8'b0000_0100, ready=0; next cycle req=8'b1000_0000 → code stays 2 until ready; then code=7.
3. RR, req held 8'hFF for 8 accepts with ready=1 → codes 7,6,5,4,3,2,1,0; 9th grant is 7.
4. RR fairness: after grant of 5, pending={6,3} → next code 3, then 6 (wrap), not 6 first.
5. Re-arm collision: valid=1, code=4, ready=1 and req[4]=1 in the same cycle → pending[4] stays 1; code 4 is granted again when next selected.
6. Reset mid-GRANT: valid=1, code=7, pending=8'hF0, rst=1 with ready=1 → next cycle valid=0, code=0, pending=0; first RR grant afterwards starts from index 7.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// Shared types for the prio_arb_enc arbiter/encoder.
//   arb_mode_t  : selection policy, FIXED (highest index first) or RR.
//   arb_state_t : grant FSM states.
package prio_arb_pkg;

    typedef enum logic {
        FIXED = 1'b0,
        RR    = 1'b1
    } arb_mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : prio_arb_pkg

// File: rtl/prio_enc_n.sv
// Combinational N-input priority encoder: index of the highest set bit.
// Ports:
//   in_vec  in  N   candidate vector
//   idx_c   out CW  index of highest set bit (0 when none set)
//   found_c out 1   at least one bit of in_vec is set
module prio_enc_n #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic [N-1:0]  in_vec,
    output logic [CW-1:0] idx_c,
    output logic          found_c
);

    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        idx_c   = '0;
        found_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (in_vec[i]) begin
                idx_c   = CW'(i);
                found_c = 1'b1;
            end
        end
    end

endmodule : prio_enc_n

// File: rtl/prio_arb_enc.sv
// Registered N-input arbiter: accumulates requests into a sticky pending
// set and presents one selected index at a time on a valid/ready handshake.
// Ports:
//   clk      in  1   clock, rising edge
//   rst      in  1   synchronous active-high reset
//   req      in  N   request bits; each set bit arms its pending bit
//   mode     in  1   0 = FIXED (highest index), 1 = round-robin; used at load
//   code     out CW  granted index, held while valid && !ready
//   valid    out 1   code holds an unaccepted grant
//   ready    in  1   consumer accepts code on valid && ready
//   pending  out N   registered pending set
module prio_arb_enc
    import prio_arb_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          mode,
    output logic [CW-1:0] code,
    output logic          valid,
    input  logic          ready,
    output logic [N-1:0]  pending
);

    localparam int unsigned SW = CW + 1;

    arb_state_t    state_q,   state_d;
    logic [CW-1:0] code_q,    code_d;
    logic          valid_q,   valid_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [CW-1:0] rr_ptr_q,  rr_ptr_d;

    logic          accept;
    logic [N-1:0]  clr;
    logic [N-1:0]  cand;
    logic [CW-1:0] ptr_eff;
    logic [N-1:0]  rot_cand;
    logic [CW-1:0] fix_idx;
    logic          fix_found;
    logic [CW-1:0] rot_idx;
    logic          rot_found;
    logic [SW-1:0] rr_sum;
    logic [CW-1:0] rr_idx;
    logic [CW-1:0] sel_idx;
    logic          sel_found;

    // Candidate set: pending minus the bit being accepted, plus same-cycle requests.
    always_comb begin
        accept = valid_q && ready;
        clr    = accept ? (N'(1) << code_q) : '0;
        cand   = (pending_q & ~clr) | req;
        // The pointer moves to the accepted code in this very cycle, so a
        // back-to-back RR load must search from that code, not the old pointer.
        ptr_eff = accept ? code_q : rr_ptr_q;
    end

    // Rotate so that index ptr_eff-1 lands on the top bit and ptr_eff on bit 0.
    always_comb begin
        int unsigned k;
        rot_cand = '0;
        for (int unsigned j = 0; j < N; j++) begin
            k = j + 32'(ptr_eff);
            if (k >= N) begin
                k = k - N;
            end
            rot_cand[j] = cand[k];
        end
    end

    prio_enc_n #(.N(N), .CW(CW)) u_enc_fixed (
        .in_vec  (cand),
        .idx_c   (fix_idx),
        .found_c (fix_found)
    );

    prio_enc_n #(.N(N), .CW(CW)) u_enc_rr (
        .in_vec  (rot_cand),
        .idx_c   (rot_idx),
        .found_c (rot_found)
    );

    // Undo the rotation modulo N and pick the policy for this load.
    always_comb begin
        rr_sum = {1'b0, rot_idx} + {1'b0, ptr_eff};
        if (rr_sum >= SW'(N)) begin
            rr_sum = rr_sum - SW'(N);
        end
        rr_idx = rr_sum[CW-1:0];

        if (arb_mode_t'(mode) == RR) begin
            sel_idx   = rr_idx;
            sel_found = rot_found;
        end else begin
            sel_idx   = fix_idx;
            sel_found = fix_found;
        end
    end

    // Grant FSM next-state and register inputs.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        valid_d   = valid_q;
        rr_ptr_d  = rr_ptr_q;
        pending_d = cand;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (sel_found) begin
                    code_d  = sel_idx;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                valid_d = 1'b1;
                if (ready) begin
                    rr_ptr_d = code_q;
                    if (sel_found) begin
                        code_d = sel_idx;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset overrides any same-cycle handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule : prio_arb_enc

// File: tb/tb_prio_arb_enc.sv
// Directed bench for prio_arb_enc with N=8.
module tb_prio_arb_enc;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic          mode;
    logic [CW-1:0] code;
    logic          valid;
    logic          ready;
    logic [N-1:0]  pending;

    int n_cmp;
    int n_err;

    prio_arb_enc #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mode    (mode),
        .code    (code),
        .valid   (valid),
        .ready   (ready),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic          mode;
        logic          ready;
        logic          ev;
        logic [CW-1:0] ec;
        logic [N-1:0]  ep;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input logic r, input logic [N-1:0] q, input logic m, input logic rd);
        rst   = r;
        req   = q;
        mode  = m;
        ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [CW-1:0] ec,
                              input logic [N-1:0] ep);
        check({tag, " valid"}, 64'(valid), 64'(ev));
        if (ev) check({tag, " code"}, 64'(code), 64'(ec));
        check({tag, " pending"}, 64'(pending), 64'(ep));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; req = '0; mode = 1'b0; ready = 1'b0;

        //               rst   req    mode  rdy  ev    ec    ep
        // Reset state
        vecs.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00});
        // FIXED burst 0100_1010: 6, 3, 1, then idle (ready while idle ignored)
        vecs.push_back('{1'b0, 8'h4A, 1'b0, 1'b1, 1'b1, 3'd6, 8'h4A});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 8'h0A});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00});
        // RR with all requests held: 7..0 then 7 again
        vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00});
        vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'hFF});
        vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd6, 8'hFF});
        vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd5, 8'hFF});
        vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd4, 8'hFF});
        vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd3, 8'hFF});
        vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd2, 8'hFF});
        vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd1, 8'hFF});
        vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF});
        vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'hFF});
        // RR fairness: grant 5, then {6,3} pending -> 3 before 6
        vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00});
        vecs.push_back('{1'b0, 8'h20, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20});
        vecs.push_back('{1'b0, 8'h48, 1'b1, 1'b1, 1'b1, 3'd3, 8'h48});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd6, 8'h40});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00});
        // Mode toggle and higher request while held: code 4 unchanged
        vecs.push_back('{1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 3'd4, 8'h12});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 8'h12});
        vecs.push_back('{1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 3'd4, 8'h92});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 8'h82});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].mode, vecs[i].ready);
            expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].ep);
        end

        // Backpressure: code 2 held against a later request for 7.
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h04, 1'b0, 1'b0);
        expect_out("bp load", 1'b1, 3'd2, 8'h04);
        step(1'b0, 8'h80, 1'b0, 1'b0);
        expect_out("bp hold0", 1'b1, 3'd2, 8'h84);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            expect_out($sformatf("bp hold%0d", i + 1), 1'b1, 3'd2, 8'h84);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        expect_out("bp next", 1'b1, 3'd7, 8'h80);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        expect_out("bp drain", 1'b0, 3'd0, 8'h00);

        // Re-arm collision on the accepted bit.
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h10, 1'b0, 1'b0);
        expect_out("rearm load", 1'b1, 3'd4, 8'h10);
        step(1'b0, 8'h10, 1'b0, 1'b1);
        expect_out("rearm again", 1'b1, 3'd4, 8'h10);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        expect_out("rearm drain", 1'b0, 3'd0, 8'h00);

        // Reset in the middle of a grant with ready high.
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'hF0, 1'b0, 1'b0);
        expect_out("rst load", 1'b1, 3'd7, 8'hF0);
        step(1'b1, 8'h00, 1'b0, 1'b1);
        expect_out("rst mid", 1'b0, 3'd0, 8'h00);
        check("rst mid code", 64'(code), 64'd0);
        step(1'b0, 8'hFF, 1'b1, 1'b0);
        expect_out("rst rr first", 1'b1, 3'd7, 8'hFF);

        // Bounded wait for the pending set to drain under RR.
        begin
            int budget;
            budget = 20;
            step(1'b0, 8'h00, 1'b1, 1'b1);
            while (valid && budget > 0) begin
                step(1'b0, 8'h00, 1'b1, 1'b1);
                budget--;
            end
            check("drain budget", 64'(budget > 0), 64'd1);
            check("drain pending", 64'(pending), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_prio_arb_enc
